// File: rtl/if_stage_if.sv
// Instruction-fetch stage bundle: decode handshake/redirect, instruction SRAM port, fs->ds bus.
// master is the fetch stage; slave is the decode stage and SRAM side.
interface if_stage_if;
  logic        ds_allow_in;
  logic        br_taken;
  logic [31:0] br_target;
  logic        inst_sram_en;
  logic        inst_sram_we;
  logic [31:0] inst_sram_addr;
  logic [31:0] inst_sram_wdata;
  logic [31:0] inst_sram_rdata;
  logic        fs_to_ds_valid;
  logic [64:0] fs_to_ds_bus;

  modport master (
    input  ds_allow_in, br_taken, br_target, inst_sram_rdata,
    output inst_sram_en, inst_sram_we, inst_sram_addr, inst_sram_wdata,
    output fs_to_ds_valid, fs_to_ds_bus
  );

  modport slave (
    output ds_allow_in, br_taken, br_target, inst_sram_rdata,
    input  inst_sram_en, inst_sram_we, inst_sram_addr, inst_sram_wdata,
    input  fs_to_ds_valid, fs_to_ds_bus
  );
endinterface

// File: rtl/if_stage.sv
// Instruction-fetch stage: one-cycle SRAM fetch, stall buffer, decode-stage redirect.
// Define FS_ADEF_CHECK_EN to flag misaligned fetch addresses instead of issuing them.
module if_stage #(
  parameter logic [31:0] RESET_PC = 32'h1c000000
) (
  input logic       clk,
  input logic       reset,
  if_stage_if.master bus
);

  logic [31:0] fs_pc_q, fs_pc_d;
  logic        fs_valid_q, fs_valid_d;
  logic [31:0] buf_q, buf_d;
  logic        buf_valid_q, buf_valid_d;

  logic [31:0] seq_pc;
  logic [31:0] nextpc;
  logic        fs_allow_in;
  logic        fs_to_ds_valid;
  logic        adef_req;
  logic        fs_adef;
  logic [31:0] fs_inst;

  assign seq_pc      = fs_pc_q + 32'd4;
  assign nextpc      = bus.br_taken ? bus.br_target : seq_pc;
  assign fs_allow_in = ~fs_valid_q | bus.ds_allow_in | bus.br_taken;

`ifdef FS_ADEF_CHECK_EN
  logic adef_q, adef_d;

  assign adef_req = |nextpc[1:0];
  assign fs_adef  = adef_q;

  always_comb begin
    adef_d = adef_q;
    if (fs_allow_in) adef_d = adef_req;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) adef_q <= 1'b0;
    else       adef_q <= adef_d;
  end
`else
  assign adef_req = 1'b0;
  assign fs_adef  = 1'b0;
`endif

  assign fs_to_ds_valid = fs_valid_q & ~bus.br_taken;

  always_comb begin
    fs_pc_d     = fs_pc_q;
    fs_valid_d  = fs_valid_q;
    buf_d       = buf_q;
    buf_valid_d = buf_valid_q;
    // A misaligned request is suppressed at the SRAM but still advances the pc.
    if (fs_allow_in) begin
      fs_pc_d    = nextpc;
      fs_valid_d = 1'b1;
    end
    if (bus.br_taken || (fs_to_ds_valid && bus.ds_allow_in)) begin
      buf_valid_d = 1'b0;
    end else if (fs_valid_q && !bus.ds_allow_in && !buf_valid_q) begin
      // SRAM data is only valid the cycle after the request; hold it across the stall.
      buf_d       = bus.inst_sram_rdata;
      buf_valid_d = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      fs_pc_q     <= RESET_PC - 32'd4;
      fs_valid_q  <= 1'b0;
      buf_q       <= 32'd0;
      buf_valid_q <= 1'b0;
    end else begin
      fs_pc_q     <= fs_pc_d;
      fs_valid_q  <= fs_valid_d;
      buf_q       <= buf_d;
      buf_valid_q <= buf_valid_d;
    end
  end

  assign fs_inst = fs_adef     ? 32'd0 :
                   buf_valid_q ? buf_q : bus.inst_sram_rdata;

  assign bus.inst_sram_en    = ~reset & fs_allow_in & ~adef_req;
  assign bus.inst_sram_we    = 1'b0;
  assign bus.inst_sram_addr  = nextpc;
  assign bus.inst_sram_wdata = 32'd0;
  assign bus.fs_to_ds_valid  = fs_to_ds_valid;
  assign bus.fs_to_ds_bus    = {fs_adef, fs_inst, fs_pc_q};

endmodule

// File: tb/tb_if_stage.sv
// Self-checking bench for if_stage: pc/valid model plus instruction-word-at-pc expectation,
// directed scenarios with literal checks.
module tb_if_stage;
  localparam logic [31:0] RESET_PC = 32'h1c000000;
`ifdef FS_ADEF_CHECK_EN
  localparam bit ADEF = 1'b1;
`else
  localparam bit ADEF = 1'b0;
`endif

  logic clk = 1'b0;
  logic reset = 1'b0;
  bit   started = 1'b0;
  int   checks = 0;
  int   failures = 0;

  if_stage_if bus ();

  if_stage #(.RESET_PC(RESET_PC)) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return {a[15:0], ~a[15:0]} ^ 32'h13579bdf;
  endfunction

  task automatic check(input string name, input logic [64:0] act, input logic [64:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Instruction SRAM: data one cycle after an enabled request, junk otherwise.
  always @(posedge clk) begin
    if (bus.inst_sram_en) bus.inst_sram_rdata <= mem_word(bus.inst_sram_addr);
    else                  bus.inst_sram_rdata <= 32'hdeadbeef;
  end

  // Model: which pc sits in fetch, whether it is valid, whether it was misaligned.
  logic [31:0] m_pc;
  bit          m_valid;
  bit          m_adef;

  function automatic logic [31:0] m_next();
    return bus.br_taken ? bus.br_target : m_pc + 32'd4;
  endfunction

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      m_pc    = RESET_PC - 32'd4;
      m_valid = 1'b0;
      m_adef  = 1'b0;
    end else if (!m_valid || bus.ds_allow_in || bus.br_taken) begin
      m_pc    = m_next();
      m_valid = 1'b1;
      m_adef  = ADEF && (m_pc[1:0] != 2'b00);
    end
  end

  always @(negedge clk) begin
    logic [31:0] np;
    bit          exp_en;
    bit          exp_valid;
    if (started) begin
      if (reset) begin
        check("rst_en", 65'(bus.inst_sram_en), 65'(0));
        check("rst_valid", 65'(bus.fs_to_ds_valid), 65'(0));
        check("rst_we", 65'(bus.inst_sram_we), 65'(0));
        check("rst_wdata", 65'(bus.inst_sram_wdata), 65'(0));
      end else begin
        np        = m_next();
        exp_en    = (!m_valid || bus.ds_allow_in || bus.br_taken) &&
                    !(ADEF && (np[1:0] != 2'b00));
        exp_valid = m_valid && !bus.br_taken;
        check("en", 65'(bus.inst_sram_en), 65'(exp_en));
        check("addr", 65'(bus.inst_sram_addr), 65'(np));
        check("we", 65'(bus.inst_sram_we), 65'(0));
        check("wdata", 65'(bus.inst_sram_wdata), 65'(0));
        check("valid", 65'(bus.fs_to_ds_valid), 65'(exp_valid));
        if (exp_valid)
          check("bus", bus.fs_to_ds_bus,
                {m_adef, (m_adef ? 32'd0 : mem_word(m_pc)), m_pc});
      end
    end
  end

  task automatic cyc(input logic ds, input logic br, input logic [31:0] tgt);
    @(posedge clk);
    #1;
    bus.ds_allow_in = ds;
    bus.br_taken    = br;
    bus.br_target   = tgt;
  endtask

  initial begin
    logic [64:0] stall_bus;
    logic [15:0] pat;
    bus.ds_allow_in = 1'b1;
    bus.br_taken    = 1'b0;
    bus.br_target   = 32'd0;
    stall_bus       = {1'b0, mem_word(32'h1c000004), 32'h1c000004};
    pat             = 16'b1011_0010_1110_0101;
    #2 reset = 1'b1;
    started = 1'b1;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;

    // Reset release and back-to-back fetch.
    @(negedge clk);
    check("first_addr", 65'(bus.inst_sram_addr), 65'(32'h1c000000));
    check("first_valid", 65'(bus.fs_to_ds_valid), 65'(0));
    cyc(1'b1, 1'b0, 32'd0);
    @(negedge clk);
    check("second_addr", 65'(bus.inst_sram_addr), 65'(32'h1c000004));
    check("second_valid", 65'(bus.fs_to_ds_valid), 65'(1));
    check("second_pc", 65'(bus.fs_to_ds_bus[31:0]), 65'(32'h1c000000));

    // Three-cycle stall at 1c000004, then delivery.
    for (int i = 0; i < 3; i++) begin
      cyc(1'b0, 1'b0, 32'd0);
      @(negedge clk);
      check("stall_en", 65'(bus.inst_sram_en), 65'(0));
      check("stall_bus", bus.fs_to_ds_bus, stall_bus);
    end
    cyc(1'b1, 1'b0, 32'd0);
    @(negedge clk);
    check("deliver_bus", bus.fs_to_ds_bus, stall_bus);
    check("deliver_addr", 65'(bus.inst_sram_addr), 65'(32'h1c000008));

    // Redirect at 1c000008.
    cyc(1'b1, 1'b1, 32'h1c000100);
    @(negedge clk);
    check("br_pc", 65'(bus.fs_to_ds_bus[31:0]), 65'(32'h1c000008));
    check("br_valid", 65'(bus.fs_to_ds_valid), 65'(0));
    check("br_addr", 65'(bus.inst_sram_addr), 65'(32'h1c000100));
    cyc(1'b1, 1'b0, 32'd0);
    @(negedge clk);
    check("br_dest_pc", 65'(bus.fs_to_ds_bus[31:0]), 65'(32'h1c000100));

    // Redirect while the stall buffer holds 1c000104.
    cyc(1'b0, 1'b0, 32'd0);
    cyc(1'b0, 1'b0, 32'd0);
    @(negedge clk);
    check("buf_inst", 65'(bus.fs_to_ds_bus[63:32]), 65'(mem_word(32'h1c000104)));
    cyc(1'b0, 1'b1, 32'h1c000200);
    @(negedge clk);
    check("buf_br_valid", 65'(bus.fs_to_ds_valid), 65'(0));
    check("buf_br_en", 65'(bus.inst_sram_en), 65'(1));
    cyc(1'b1, 1'b0, 32'd0);
    @(negedge clk);
    check("buf_br_bus", bus.fs_to_ds_bus,
          {1'b0, mem_word(32'h1c000200), 32'h1c000200});

    // Asynchronous reset in the middle of a stall.
    cyc(1'b0, 1'b0, 32'd0);
    cyc(1'b0, 1'b0, 32'd0);
    @(posedge clk);
    #2 reset = 1'b1;
    #1;
    check("async_valid", 65'(bus.fs_to_ds_valid), 65'(0));
    check("async_en", 65'(bus.inst_sram_en), 65'(0));
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    bus.ds_allow_in = 1'b1;
    @(negedge clk);
    check("rerun_addr", 65'(bus.inst_sram_addr), 65'(32'h1c000000));
    check("rerun_en", 65'(bus.inst_sram_en), 65'(1));

    // Misaligned redirect target.
    cyc(1'b1, 1'b0, 32'd0);
    cyc(1'b1, 1'b0, 32'd0);
    cyc(1'b1, 1'b1, 32'h1c000102);
    @(negedge clk);
    check("mis_en", 65'(bus.inst_sram_en), 65'(!ADEF));
    cyc(1'b1, 1'b0, 32'd0);
    @(negedge clk);
    check("mis_pc", 65'(bus.fs_to_ds_bus[31:0]), 65'(32'h1c000102));
    check("mis_adef", 65'(bus.fs_to_ds_bus[64]), 65'(ADEF));
    check("mis_inst", 65'(bus.fs_to_ds_bus[63:32]),
          65'(ADEF ? 32'd0 : mem_word(32'h1c000102)));

    // Mixed accept/stall pattern from an aligned target.
    cyc(1'b1, 1'b1, 32'h1c000300);
    for (int i = 0; i < 16; i++) cyc(pat[i], 1'b0, 32'd0);
    repeat (3) cyc(1'b1, 1'b0, 32'd0);
    @(negedge clk);
    #1;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
